// File: rtl/ysyx_lsu_if.sv
// ysyx_lsu_if -- load/store bus bundle between the LSU and the memory side.
//   AR/R : arvalid_o, araddr_o, arsize_o -> ; <- arready, rvalid, rdata, rresp ; rready_o ->
//   AW/W : awvalid_o, awaddr_o, awsize_o, wvalid_o, wdata_o, wstrb_o -> ; <- awready, wready
//   B    : <- bvalid, bresp ; bready_o ->
// Signals keep the LSU-side naming (_o = driven by the LSU).
interface ysyx_lsu_if #(parameter int BIT_W = 32) ();
  logic             arvalid_o;
  logic [BIT_W-1:0] araddr_o;
  logic [2:0]       arsize_o;
  logic             arready;
  logic             rvalid;
  logic [BIT_W-1:0] rdata;
  logic [1:0]       rresp;
  logic             rready_o;
  logic             awvalid_o;
  logic [BIT_W-1:0] awaddr_o;
  logic [2:0]       awsize_o;
  logic             awready;
  logic             wvalid_o;
  logic [BIT_W-1:0] wdata_o;
  logic [3:0]       wstrb_o;
  logic             wready;
  logic             bvalid;
  logic [1:0]       bresp;
  logic             bready_o;

  modport master (
    output arvalid_o, araddr_o, arsize_o, rready_o,
           awvalid_o, awaddr_o, awsize_o, wvalid_o, wdata_o, wstrb_o, bready_o,
    input  arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp
  );
  modport slave (
    input  arvalid_o, araddr_o, arsize_o, rready_o,
           awvalid_o, awaddr_o, awsize_o, wvalid_o, wdata_o, wstrb_o, bready_o,
    output arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp
  );
endinterface

// File: rtl/ysyx_lsu.sv
// ysyx_lsu -- single-outstanding load/store unit between EXU and a valid/ready bus.
//   clk, rst            : clock, synchronous active-high reset
//   lsu_avalid          : request, held until completion; sampled only in IDLE
//   lsu_addr/ren/wen    : byte address and direction (ren&wen = load)
//   lsu_func3           : [1:0] size (byte/half/word), [2] unsigned load
//   lsu_wdata           : right-aligned store data
//   lsu_rdata_o         : last load result, aligned and extended
//   lsu_exu_rvalid_o    : one-cycle load completion
//   lsu_exu_wready_o    : one-cycle store completion
//   lsu_err_o           : misaligned or bus error, valid with a completion pulse
//   bus                 : master side of ysyx_lsu_if
// All bus outputs come from registers or the state only.
module ysyx_lsu #(
  parameter int BIT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lsu_avalid,
  input  logic [BIT_W-1:0] lsu_addr,
  input  logic             lsu_ren,
  input  logic             lsu_wen,
  input  logic [2:0]       lsu_func3,
  input  logic [BIT_W-1:0] lsu_wdata,
  output logic [BIT_W-1:0] lsu_rdata_o,
  output logic             lsu_exu_rvalid_o,
  output logic             lsu_exu_wready_o,
  output logic             lsu_err_o,
  ysyx_lsu_if.master       bus
);
  typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR_AW, WR_B, DONE} state_e;

  state_e           state_q, state_d;
  logic [BIT_W-1:0] addr_q, wdata_q, rdata_q;
  logic [2:0]       func3_q;
  logic             store_q, err_q, aw_done_q, w_done_q;
  logic             req_store, req_misal;
  logic [1:0]       off_q;
  logic [BIT_W-1:0] rsh, load_ext;
  logic [3:0]       strb_base;

  assign req_store = lsu_wen & ~lsu_ren;
  assign off_q     = addr_q[1:0];

  always_comb begin
    case (lsu_func3[1:0])
      2'd0:    req_misal = 1'b0;
      2'd1:    req_misal = lsu_addr[0];
      default: req_misal = |lsu_addr[1:0];
    endcase
  end

  // Load alignment/extension; the result is registered on the R handshake,
  // so rdata_q only changes as a load completes.
  assign rsh = bus.rdata >> {off_q, 3'b000};
  always_comb begin
    case (func3_q[1:0])
      2'd0:    load_ext = {{(BIT_W-8){~func3_q[2] & rsh[7]}}, rsh[7:0]};
      2'd1:    load_ext = {{(BIT_W-16){~func3_q[2] & rsh[15]}}, rsh[15:0]};
      default: load_ext = rsh;
    endcase
  end

  always_comb begin
    case (func3_q[1:0])
      2'd0:    strb_base = 4'b0001;
      2'd1:    strb_base = 4'b0011;
      default: strb_base = 4'b1111;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (lsu_avalid) state_d = req_misal ? DONE : (req_store ? WR_AW : RD_A);
      RD_A:  if (bus.arready) state_d = RD_D;
      RD_D:  if (bus.rvalid) state_d = DONE;
      // AW and W complete independently; leave once both are through,
      // counting a handshake that lands this cycle.
      WR_AW: if ((aw_done_q | bus.awready) & (w_done_q | bus.wready)) state_d = WR_B;
      WR_B:  if (bus.bvalid) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      func3_q   <= '0;
      store_q   <= 1'b0;
      err_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (lsu_avalid) begin
          addr_q    <= lsu_addr;
          func3_q   <= lsu_func3;
          wdata_q   <= lsu_wdata;
          store_q   <= req_store;
          err_q     <= req_misal;
          aw_done_q <= 1'b0;
          w_done_q  <= 1'b0;
        end
        RD_D: if (bus.rvalid) begin
          err_q   <= |bus.rresp;
          rdata_q <= load_ext;     // updated even on a bus error
        end
        WR_AW: begin
          if (bus.awready) aw_done_q <= 1'b1;
          if (bus.wready)  w_done_q  <= 1'b1;
        end
        WR_B: if (bus.bvalid) err_q <= |bus.bresp;
        default: ;
      endcase
    end
  end

  assign bus.arvalid_o = (state_q == RD_A);
  assign bus.araddr_o  = addr_q;
  assign bus.arsize_o  = {1'b0, func3_q[1:0]};
  assign bus.rready_o  = (state_q == RD_D);
  assign bus.awvalid_o = (state_q == WR_AW) & ~aw_done_q;
  assign bus.awaddr_o  = addr_q;
  assign bus.awsize_o  = {1'b0, func3_q[1:0]};
  assign bus.wvalid_o  = (state_q == WR_AW) & ~w_done_q;
  assign bus.wdata_o   = wdata_q << {off_q, 3'b000};
  assign bus.wstrb_o   = strb_base << off_q;
  assign bus.bready_o  = (state_q == WR_B);

  assign lsu_rdata_o      = rdata_q;
  assign lsu_exu_rvalid_o = (state_q == DONE) & ~store_q;
  assign lsu_exu_wready_o = (state_q == DONE) &  store_q;
  assign lsu_err_o        = (state_q == DONE) &  err_q;
endmodule

// File: tb/tb_ysyx_lsu.sv
// tb_ysyx_lsu -- directed vector table, reset-abort sequence and randomized
// traffic for ysyx_lsu, with a cycle-level bus slave and a reference model.
module tb_ysyx_lsu;
  localparam int BIT_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              lsu_avalid, lsu_ren, lsu_wen;
  logic [BIT_W-1:0]  lsu_addr, lsu_wdata, lsu_rdata_o;
  logic [2:0]        lsu_func3;
  logic              lsu_exu_rvalid_o, lsu_exu_wready_o, lsu_err_o;

  ysyx_lsu_if #(.BIT_W(BIT_W)) bus ();

  ysyx_lsu #(.BIT_W(BIT_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .lsu_avalid       (lsu_avalid),
    .lsu_addr         (lsu_addr),
    .lsu_ren          (lsu_ren),
    .lsu_wen          (lsu_wen),
    .lsu_func3        (lsu_func3),
    .lsu_wdata        (lsu_wdata),
    .lsu_rdata_o      (lsu_rdata_o),
    .lsu_exu_rvalid_o (lsu_exu_rvalid_o),
    .lsu_exu_wready_o (lsu_exu_wready_o),
    .lsu_err_o        (lsu_err_o),
    .bus              (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        ren, wen;
    logic [2:0]  f3;
    logic [31:0] wdata;
    logic [31:0] rdata;      // what the slave returns
    logic [1:0]  resp;       // rresp / bresp
    int          ar_w, r_w, aw_w, w_w, b_w;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_strb;
    int          exp_lat;    // cycles from first avalid cycle to pulse, inclusive
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---- reference model: byte-lane arithmetic on the request ----
  function automatic int nbytes(input logic [2:0] f3);
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit ref_misal(input logic [31:0] addr, input logic [2:0] f3);
    return (int'(addr[1:0]) % nbytes(f3)) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [31:0] addr,
                                           input logic [2:0] f3);
    longint unsigned v, lim;
    int off;
    off = int'(addr[1:0]);
    lim = 64'd1 << (8 * nbytes(f3));
    v   = word;
    v   = (v / (64'd1 << (8 * off))) % lim;
    if (!f3[2] && nbytes(f3) < 4 && v >= lim / 2) v = v + 64'h1_0000_0000 - lim;
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] wd, input logic [31:0] addr);
    longint unsigned v;
    v = wd;
    v = v * (64'd1 << (8 * int'(addr[1:0])));
    return v[31:0];
  endfunction

  function automatic logic [3:0] ref_strb(input logic [31:0] addr, input logic [2:0] f3);
    int s;
    s = ((1 << nbytes(f3)) - 1) << int'(addr[1:0]);
    return s[3:0];
  endfunction

  task automatic slave_idle();
    bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = '0;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = '0;
  endtask

  // Issue one request starting at a negedge, play the bus slave with the
  // given wait counts, and check the whole transaction.
  task automatic run_op(input vec_t v, input string tag);
    bit ar_seen, aw_seen, w_seen, ar_done, r_done, aw_done, w_done, b_done, prot;
    bit comp, got_load, got_store, got_err, is_load, misal;
    int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt, b_cyc, comp_cyc, pulses;
    logic [31:0] got_rd, got_hold, g_araddr, g_awaddr, g_wdata;
    logic [2:0]  g_arsize, g_awsize;
    logic [3:0]  g_strb;
    {ar_seen, aw_seen, w_seen, ar_done, r_done, aw_done, w_done, b_done, prot} = '0;
    {comp, got_load, got_store, got_err} = '0;
    {ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt, b_cyc, comp_cyc, pulses} = '0;
    {got_rd, got_hold, g_araddr, g_awaddr, g_wdata, g_arsize, g_awsize, g_strb} = '0;
    is_load = !(v.wen && !v.ren);
    misal   = ref_misal(v.addr, v.f3);
    lsu_addr = v.addr; lsu_ren = v.ren; lsu_wen = v.wen; lsu_func3 = v.f3;
    lsu_wdata = v.wdata; lsu_avalid = 1'b1;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(posedge clk); @(negedge clk);
      if (comp && cyc == comp_cyc + 1) got_hold = lsu_rdata_o;
      if (lsu_exu_rvalid_o || lsu_exu_wready_o) begin
        pulses++;
        if (!comp) begin
          comp = 1; comp_cyc = cyc;
          got_load = lsu_exu_rvalid_o; got_store = lsu_exu_wready_o;
          got_err = lsu_err_o; got_rd = lsu_rdata_o;
          lsu_avalid = 1'b0;
        end
      end
      // AR / R
      if (bus.arvalid_o) begin
        if (!ar_seen) begin g_araddr = bus.araddr_o; g_arsize = bus.arsize_o; end
        if (ar_done || (ar_seen && (bus.araddr_o !== g_araddr))) prot = 1;
        ar_seen = 1;
      end else if (ar_seen && !ar_done) prot = 1;
      bus.arready = bus.arvalid_o && (ar_cnt >= v.ar_w);
      if (bus.arvalid_o) ar_cnt++;
      bus.rvalid = ar_done && !r_done && (r_cnt >= v.r_w);
      bus.rdata  = v.rdata; bus.rresp = v.resp;
      if (ar_done && !r_done) r_cnt++;
      // AW / W / B
      if (bus.awvalid_o) begin
        if (!aw_seen) begin
          g_awaddr = bus.awaddr_o; g_awsize = bus.awsize_o;
          if (!bus.wvalid_o && !w_done) prot = 1;
        end
        if (aw_done) prot = 1;
        aw_seen = 1;
      end else if (aw_seen && !aw_done) prot = 1;
      if (bus.wvalid_o) begin
        if (!w_seen) begin
          g_wdata = bus.wdata_o; g_strb = bus.wstrb_o;
          if (!bus.awvalid_o && !aw_done) prot = 1;
        end
        if (w_done) prot = 1;
        w_seen = 1;
      end else if (w_seen && !w_done) prot = 1;
      bus.awready = bus.awvalid_o && (aw_cnt >= v.aw_w);
      if (bus.awvalid_o) aw_cnt++;
      bus.wready = bus.wvalid_o && (w_cnt >= v.w_w);
      if (bus.wvalid_o) w_cnt++;
      bus.bvalid = aw_done && w_done && !b_done && (b_cnt >= v.b_w);
      bus.bresp  = v.resp;
      if (aw_done && w_done && !b_done) b_cnt++;
      // handshakes land on the coming posedge
      if (bus.arvalid_o && bus.arready) ar_done = 1;
      if (bus.rvalid && bus.rready_o)   r_done  = 1;
      if (bus.awvalid_o && bus.awready) aw_done = 1;
      if (bus.wvalid_o && bus.wready)   w_done  = 1;
      if (bus.bvalid && bus.bready_o) begin b_done = 1; b_cyc = cyc; end
      if (comp && cyc == comp_cyc + 1) break;
    end
    slave_idle();
    lsu_avalid = 1'b0;
    chk({tag, " completed"}, 32'(comp), 32'd1);
    if (comp) begin
      chk({tag, " pulse kind"}, {got_load, got_store}, is_load ? 32'd2 : 32'd1);
      chk({tag, " pulse count"}, pulses, 32'd1);
      chk({tag, " err"}, 32'(got_err), 32'(v.exp_err));
      chk({tag, " rdata"}, got_rd, v.exp_rdata);
      chk({tag, " rdata hold"}, got_hold, v.exp_rdata);
      chk({tag, " latency"}, comp_cyc + 1, v.exp_lat);
      chk({tag, " protocol"}, 32'(prot), 32'd0);
      if (misal) begin
        chk({tag, " no bus"}, {ar_seen, aw_seen, w_seen}, 32'd0);
      end else if (is_load) begin
        chk({tag, " araddr"}, g_araddr, v.addr);
        chk({tag, " arsize"}, g_arsize, {1'b0, v.f3[1:0]});
        chk({tag, " no write"}, {aw_seen, w_seen}, 32'd0);
      end else begin
        chk({tag, " awaddr"}, g_awaddr, v.addr);
        chk({tag, " awsize"}, g_awsize, {1'b0, v.f3[1:0]});
        chk({tag, " wdata"}, g_wdata, v.exp_wdata);
        chk({tag, " wstrb"}, g_strb, v.exp_strb);
        chk({tag, " no read"}, 32'(ar_seen), 32'd0);
        chk({tag, " pulse after b"}, 32'(b_done && comp_cyc > b_cyc), 32'd1);
      end
    end
  endtask

  vec_t tbl[12];
  vec_t rv;

  initial begin
    //        addr          ren  wen  f3      wdata         rdata         resp  ar r aw w b  exp_rdata     err  exp_wdata     strb     lat
    tbl[0]  = '{32'h80000003, 1'b1, 1'b0, 3'b000, 32'h0,        32'h80FF1234, 2'd0, 0,0,0,0,0, 32'hFFFFFF80, 1'b0, 32'h0,        4'b0000, 4};
    tbl[1]  = '{32'h80000002, 1'b1, 1'b0, 3'b101, 32'h0,        32'hBEEF0000, 2'd0, 1,2,0,0,0, 32'h0000BEEF, 1'b0, 32'h0,        4'b0000, 7};
    tbl[2]  = '{32'h80000002, 1'b0, 1'b1, 3'b001, 32'h1234ABCD, 32'h0,        2'd0, 0,0,0,2,1, 32'h0000BEEF, 1'b0, 32'hABCD0000, 4'b1100, 7};
    tbl[3]  = '{32'h80000001, 1'b1, 1'b0, 3'b010, 32'h0,        32'h11111111, 2'd0, 0,0,0,0,0, 32'h0000BEEF, 1'b1, 32'h0,        4'b0000, 2};
    tbl[4]  = '{32'h80000010, 1'b0, 1'b1, 3'b010, 32'hDEADBEEF, 32'h0,        2'd2, 0,0,0,0,0, 32'h0000BEEF, 1'b1, 32'hDEADBEEF, 4'b1111, 4};
    tbl[5]  = '{32'h80000014, 1'b1, 1'b0, 3'b010, 32'h0,        32'h12345678, 2'd0, 0,0,0,0,0, 32'h12345678, 1'b0, 32'h0,        4'b0000, 4};
    tbl[6]  = '{32'h80000001, 1'b1, 1'b0, 3'b100, 32'h0,        32'h0000AB00, 2'd2, 0,1,0,0,0, 32'h000000AB, 1'b1, 32'h0,        4'b0000, 5};
    tbl[7]  = '{32'h80000003, 1'b0, 1'b1, 3'b000, 32'h000000A5, 32'h0,        2'd0, 0,0,3,0,0, 32'h000000AB, 1'b0, 32'hA5000000, 4'b1000, 7};
    tbl[8]  = '{32'h80000020, 1'b0, 1'b1, 3'b010, 32'h11223344, 32'h0,        2'd0, 0,0,0,0,0, 32'h000000AB, 1'b0, 32'h11223344, 4'b1111, 4};
    tbl[9]  = '{32'h80000004, 1'b1, 1'b1, 3'b001, 32'h0,        32'h00008001, 2'd0, 0,0,0,0,0, 32'hFFFF8001, 1'b0, 32'h0,        4'b0000, 4};
    tbl[10] = '{32'h80000005, 1'b0, 1'b1, 3'b001, 32'h00005555, 32'h0,        2'd0, 0,0,0,0,0, 32'hFFFF8001, 1'b1, 32'h0,        4'b0000, 2};
    tbl[11] = '{32'h80000002, 1'b1, 1'b0, 3'b001, 32'h0,        32'h7FFF0000, 2'd0, 2,0,0,0,0, 32'h00007FFF, 1'b0, 32'h0,        4'b0000, 6};

    rst = 1'b1; lsu_avalid = 1'b0; lsu_ren = 1'b0; lsu_wen = 1'b0;
    lsu_addr = '0; lsu_wdata = '0; lsu_func3 = '0;
    slave_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset valids", {bus.arvalid_o, bus.awvalid_o, bus.wvalid_o, bus.rready_o, bus.bready_o,
                         lsu_exu_rvalid_o, lsu_exu_wready_o, lsu_err_o}, 32'd0);
    chk("reset rdata", lsu_rdata_o, 32'd0);
    rst = 1'b0;

    foreach (tbl[i]) run_op(tbl[i], $sformatf("vec%0d", i));

    // Reset while the read data is being offered.
    lsu_addr = 32'h80000008; lsu_ren = 1'b1; lsu_wen = 1'b0; lsu_func3 = 3'b010;
    lsu_avalid = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rstabort arvalid", 32'(bus.arvalid_o), 32'd1);
    bus.arready = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.arready = 1'b0;
    chk("rstabort rready", 32'(bus.rready_o), 32'd1);
    bus.rvalid = 1'b1; bus.rdata = 32'h55AA55AA; bus.rresp = 2'd0;
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rstabort outputs", {bus.arvalid_o, bus.rready_o, lsu_exu_rvalid_o, lsu_exu_wready_o,
                             lsu_err_o}, 32'd0);
    chk("rstabort rdata", lsu_rdata_o, 32'd0);
    rst = 1'b0; lsu_avalid = 1'b0;
    slave_idle();
    @(posedge clk); @(negedge clk);
    chk("rstabort idle", {bus.arvalid_o, bus.rready_o, lsu_exu_rvalid_o, lsu_exu_wready_o}, 32'd0);
    model_rdata = 32'd0;
    rv = '{32'h8000000C, 1'b1, 1'b0, 3'b010, 32'h0, 32'hCAFEF00D, 2'd0, 0,0,0,0,0,
           32'hCAFEF00D, 1'b0, 32'h0, 4'b0000, 4};
    run_op(rv, "postrst");
    model_rdata = 32'hCAFEF00D;

    // Randomized traffic against the reference model.
    for (int n = 0; n < 250; n++) begin
      int sel;
      bit ld, mis;
      sel = $urandom_range(0, 3);
      rv.ren = (sel != 1); rv.wen = (sel == 1 || sel == 2);
      rv.f3 = {1'($urandom_range(0, 1)), 2'($urandom_range(0, 2))};
      rv.addr = 32'h80000000 | ($urandom & 32'h00000FFF);
      rv.wdata = $urandom; rv.rdata = $urandom;
      rv.resp = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      rv.ar_w = $urandom_range(0, 3); rv.r_w = $urandom_range(0, 3);
      rv.aw_w = $urandom_range(0, 3); rv.w_w = $urandom_range(0, 3); rv.b_w = $urandom_range(0, 3);
      ld  = !(rv.wen && !rv.ren);
      mis = ref_misal(rv.addr, rv.f3);
      if (ld && !mis) model_rdata = ref_load(rv.rdata, rv.addr, rv.f3);
      rv.exp_rdata = model_rdata;
      rv.exp_err   = mis || (rv.resp != 2'd0);
      rv.exp_wdata = ref_wdata(rv.wdata, rv.addr);
      rv.exp_strb  = ref_strb(rv.addr, rv.f3);
      rv.exp_lat   = mis ? 2 : ld ? rv.ar_w + rv.r_w + 4
                               : ((rv.aw_w > rv.w_w) ? rv.aw_w : rv.w_w) + rv.b_w + 4;
      run_op(rv, $sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
